// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - execute, memory-request/response and writeback signals of the memory-access stage
interface mem_access_stage_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [63:0] alu_res_i;
  logic [63:0] store_data_i;
  logic [1:0]  mem_op_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [4:0]  rd_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [63:0] req_addr_o;
  logic        req_we_o;
  logic [63:0] req_wdata_o;
  logic [7:0]  req_strb_o;
  logic        rsp_valid_i;
  logic [63:0] rsp_rdata_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic        misalign_o;

  modport slave (
    input  ex_valid_i, alu_res_i, store_data_i, mem_op_i, size_i, unsigned_i, rd_i,
    input  req_ready_i, rsp_valid_i, rsp_rdata_i,
    output ex_ready_o, req_valid_o, req_addr_o, req_we_o, req_wdata_o, req_strb_o,
    output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misalign_o
  );

  modport master (
    output ex_valid_i, alu_res_i, store_data_i, mem_op_i, size_i, unsigned_i, rd_i,
    output req_ready_i, rsp_valid_i, rsp_rdata_i,
    input  ex_ready_o, req_valid_o, req_addr_o, req_we_o, req_wdata_o, req_strb_o,
    input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misalign_o
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV64 memory-access stage: one outstanding load/store, lane alignment, load extension
module mem_access_stage (
  input logic             clk,
  input logic             reset,
  mem_access_stage_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [1:0]  r_op;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [4:0]  r_rd;

  logic        r_wb_valid;
  logic        r_wb_we;
  logic [4:0]  r_wb_rd;
  logic [63:0] r_wb_data;
  logic        r_misalign;

  logic        w_capture;
  logic        w_in_mem;
  logic        w_aligned;
  logic        w_wb_valid;
  logic        w_wb_we;
  logic [4:0]  w_wb_rd;
  logic [63:0] w_wb_data;
  logic        w_misalign;
  logic        w_req_active;
  logic [2:0]  w_off;
  logic [7:0]  w_strb;
  logic [63:0] w_rsp_shift;
  logic [63:0] w_load_ext;

  assign w_in_mem = (bus.mem_op_i == OP_LOAD) || (bus.mem_op_i == OP_STORE);

  always_comb begin
    w_aligned = 1'b1;
    case (bus.size_i)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = (bus.alu_res_i[0] == 1'b0);
      2'b10:   w_aligned = (bus.alu_res_i[1:0] == 2'b00);
      default: w_aligned = (bus.alu_res_i[2:0] == 3'b000);
    endcase
  end

  assign w_off        = r_addr[2:0];
  assign w_req_active = (r_state == S_REQ);

  always_comb begin
    w_strb = 8'hFF;
    case (r_size)
      2'b00:   w_strb = 8'h01 << w_off;
      2'b01:   w_strb = 8'h03 << w_off;
      2'b10:   w_strb = 8'h0F << w_off;
      default: w_strb = 8'hFF;
    endcase
  end

  assign w_rsp_shift = bus.rsp_rdata_i >> {w_off, 3'b000};

  always_comb begin
    w_load_ext = w_rsp_shift;
    case (r_size)
      2'b00:   w_load_ext = r_unsigned ? {56'd0, w_rsp_shift[7:0]}
                                       : {{56{w_rsp_shift[7]}}, w_rsp_shift[7:0]};
      2'b01:   w_load_ext = r_unsigned ? {48'd0, w_rsp_shift[15:0]}
                                       : {{48{w_rsp_shift[15]}}, w_rsp_shift[15:0]};
      2'b10:   w_load_ext = r_unsigned ? {32'd0, w_rsp_shift[31:0]}
                                       : {{32{w_rsp_shift[31]}}, w_rsp_shift[31:0]};
      default: w_load_ext = w_rsp_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Non-memory and misaligned ops retire straight from IDLE without touching the bus
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_wb_valid  = 1'b0;
    w_wb_we     = 1'b0;
    w_wb_rd     = 5'd0;
    w_wb_data   = 64'd0;
    w_misalign  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ex_valid_i) begin
          w_capture = 1'b1;
          if (!w_in_mem) begin
            w_wb_valid = 1'b1;
            w_wb_we    = (bus.rd_i != 5'd0);
            w_wb_rd    = bus.rd_i;
            w_wb_data  = bus.alu_res_i;
          end else if (!w_aligned) begin
            w_wb_valid = 1'b1;
            w_wb_rd    = bus.rd_i;
            w_misalign = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.req_ready_i) begin
          w_state_nxt = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (bus.rsp_valid_i) begin
          w_state_nxt = S_IDLE;
          w_wb_valid  = 1'b1;
          w_wb_rd     = r_rd;
          if (r_op == OP_LOAD) begin
            w_wb_we   = (r_rd != 5'd0);
            w_wb_data = w_load_ext;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_op       <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_rd       <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 64'd0;
      r_misalign <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr     <= bus.alu_res_i;
        r_wdata    <= bus.store_data_i;
        r_op       <= bus.mem_op_i;
        r_size     <= bus.size_i;
        r_unsigned <= bus.unsigned_i;
        r_rd       <= bus.rd_i;
      end
      r_wb_valid <= w_wb_valid;
      r_wb_we    <= w_wb_we;
      r_wb_rd    <= w_wb_rd;
      r_wb_data  <= w_wb_data;
      r_misalign <= w_misalign;
    end
  end

  // Request fields are forced to zero outside REQ so idle/reset values are clean
  assign bus.ex_ready_o  = (r_state == S_IDLE);
  assign bus.req_valid_o = w_req_active;
  assign bus.req_addr_o  = w_req_active ? {r_addr[63:3], 3'b000} : 64'd0;
  assign bus.req_we_o    = w_req_active && (r_op == OP_STORE);
  assign bus.req_strb_o  = !w_req_active ? 8'h00 : ((r_op == OP_LOAD) ? 8'hFF : w_strb);
  assign bus.req_wdata_o = (w_req_active && (r_op == OP_STORE)) ? (r_wdata << {w_off, 3'b000}) : 64'd0;

  assign bus.wb_valid_o = r_wb_valid;
  assign bus.wb_we_o    = r_wb_we;
  assign bus.wb_rd_o    = r_wb_rd;
  assign bus.wb_data_o  = r_wb_data;
  assign bus.misalign_o = r_misalign;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input int nb, input bit uns);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input int off, input int nb, input bit is_load);
    logic [7:0] s;
    s = 8'h00;
    if (is_load) return 8'hFF;
    for (int i = 0; i < nb; i++) s[off+i] = 1'b1;
    return s;
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ex_ready"},  bus.ex_ready_o, 1);
    chk({pfx, "_req_valid"}, bus.req_valid_o, 0);
    chk({pfx, "_req_we"},    bus.req_we_o, 0);
    chk({pfx, "_req_addr"},  bus.req_addr_o, 0);
    chk({pfx, "_req_wdata"}, bus.req_wdata_o, 0);
    chk({pfx, "_req_strb"},  bus.req_strb_o, 0);
    chk({pfx, "_wb_valid"},  bus.wb_valid_o, 0);
    chk({pfx, "_wb_we"},     bus.wb_we_o, 0);
    chk({pfx, "_wb_rd"},     bus.wb_rd_o, 0);
    chk({pfx, "_wb_data"},   bus.wb_data_o, 0);
    chk({pfx, "_misalign"},  bus.misalign_o, 0);
  endtask

  // Entered and left just after a falling edge; every wait is a fixed cycle count.
  task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input int rdy_dly, input int rsp_dly,
                        input bit early_rsp);
    int nb;
    int off;
    bit mem;
    bit aligned;
    bit is_load;
    nb      = 1 << sz;
    off     = int'(addr[2:0]);
    mem     = (op == 2'b01) || (op == 2'b10);
    is_load = (op == 2'b01);
    aligned = (addr % 64'(nb)) == 0;

    chk("ex_ready_idle", bus.ex_ready_o, 1);
    bus.ex_valid_i   = 1'b1;
    bus.mem_op_i     = op;
    bus.size_i       = sz;
    bus.unsigned_i   = uns;
    bus.rd_i         = rd;
    bus.alu_res_i    = addr;
    bus.store_data_i = sdata;
    @(negedge clk);
    bus.ex_valid_i = 1'b0;

    if (!mem || !aligned) begin
      chk("imm_wb_valid", bus.wb_valid_o, 1);
      chk("imm_misalign", bus.misalign_o, mem);
      chk("imm_wb_we",    bus.wb_we_o, (!mem && rd != 0));
      chk("imm_wb_data",  bus.wb_data_o, mem ? 64'd0 : addr);
      if (!mem) chk("imm_wb_rd", bus.wb_rd_o, rd);
      chk("imm_no_req",   bus.req_valid_o, 0);
      chk("imm_ex_ready", bus.ex_ready_o, 1);
      return;
    end

    for (int c = 0; c <= rdy_dly; c++) begin
      if (c == rdy_dly) begin
        bus.req_ready_i = 1'b1;
        if (early_rsp) begin
          bus.rsp_valid_i = 1'b1;
          bus.rsp_rdata_i = ~rdata;
        end
      end
      chk("req_valid", bus.req_valid_o, 1);
      chk("req_addr",  bus.req_addr_o, addr & ~64'h7);
      chk("req_we",    bus.req_we_o, !is_load);
      chk("req_strb",  bus.req_strb_o, model_strb(off, nb, is_load));
      if (!is_load) chk("req_wdata", bus.req_wdata_o, sdata << (8 * off));
      chk("req_ex_ready", bus.ex_ready_o, 0);
      chk("req_no_wb", bus.wb_valid_o, 0);
      @(negedge clk);
    end
    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;

    for (int c = 0; c <= rsp_dly; c++) begin
      chk("wait_req_valid", bus.req_valid_o, 0);
      chk("wait_ex_ready",  bus.ex_ready_o, 0);
      chk("wait_no_wb",     bus.wb_valid_o, 0);
      if (c == rsp_dly) begin
        bus.rsp_valid_i = 1'b1;
        bus.rsp_rdata_i = rdata;
      end
      @(negedge clk);
    end
    bus.rsp_valid_i = 1'b0;

    chk("mem_wb_valid", bus.wb_valid_o, 1);
    chk("mem_wb_we",    bus.wb_we_o, (is_load && rd != 0));
    chk("mem_wb_data",  bus.wb_data_o, is_load ? model_load(rdata, off, nb, uns) : 64'd0);
    chk("mem_wb_rd",    bus.wb_rd_o, rd);
    chk("mem_misalign", bus.misalign_o, 0);
    chk("mem_ex_ready", bus.ex_ready_o, 1);
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  op;
    logic [1:0]  sz;

    bus.ex_valid_i   = 1'b0;
    bus.alu_res_i    = 64'd0;
    bus.store_data_i = 64'd0;
    bus.mem_op_i     = 2'b00;
    bus.size_i       = 2'b00;
    bus.unsigned_i   = 1'b0;
    bus.rd_i         = 5'd0;
    bus.req_ready_i  = 1'b0;
    bus.rsp_valid_i  = 1'b0;
    bus.rsp_rdata_i  = 64'd0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");

    // Non-memory op with and without a destination, back to back
    run_op(2'b00, 2'b11, 1'b0, 5'd5, 64'h1234, 64'd0, 64'd0, 0, 0, 0);
    run_op(2'b00, 2'b11, 1'b0, 5'd0, 64'h1234, 64'd0, 64'd0, 0, 0, 0);
    run_op(2'b11, 2'b10, 1'b0, 5'd7, 64'hABCD, 64'd0, 64'd0, 0, 0, 0);

    // Byte load at 0x1003, signed then unsigned
    run_op(2'b01, 2'b00, 1'b0, 5'd3, 64'h1003, 64'd0, 64'h00000000_80000000, 0, 0, 0);
    chk("ld_s_expect", model_load(64'h00000000_80000000, 3, 1, 0), 64'hFFFFFFFF_FFFFFF80);
    run_op(2'b01, 2'b00, 1'b1, 5'd3, 64'h1003, 64'd0, 64'h00000000_80000000, 0, 0, 0);

    // Word store at 0x2004
    run_op(2'b10, 2'b10, 1'b0, 5'd9, 64'h2004, 64'hDEADBEEF, 64'd0, 0, 0, 0);

    // Backpressure with a response offered during the handshake, then a single pulse
    run_op(2'b01, 2'b11, 1'b0, 5'd12, 64'h3008, 64'd0, 64'h8123_4567_89AB_CDEF, 4, 3, 1);
    @(negedge clk);
    chk("single_pulse", bus.wb_valid_o, 0);

    // Misaligned half load
    run_op(2'b01, 2'b01, 1'b0, 5'd4, 64'h1001, 64'd0, 64'd0, 0, 0, 0);

    // Reset while waiting for a response, then a stale response
    bus.ex_valid_i = 1'b1;
    bus.mem_op_i   = 2'b01;
    bus.size_i     = 2'b11;
    bus.rd_i       = 5'd6;
    bus.alu_res_i  = 64'h4000;
    @(negedge clk);
    bus.ex_valid_i  = 1'b0;
    bus.req_ready_i = 1'b1;
    @(negedge clk);
    bus.req_ready_i = 1'b0;
    chk("pre_rst_busy", bus.ex_ready_o, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midrst");
    bus.rsp_valid_i = 1'b1;
    bus.rsp_rdata_i = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    bus.rsp_valid_i = 1'b0;
    chk("late_rsp_no_wb", bus.wb_valid_o, 0);
    chk("late_rsp_ready", bus.ex_ready_o, 1);
    chk("late_rsp_noreq", bus.req_valid_o, 0);

    // Randomized mix against the reference model
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      a  = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      run_op(op, sz, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), a,
             {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
